// File: rtl/cp0_exc_if.sv
// CP0 exception unit bus: mtc0/mfc0 access, M-stage exception inputs,
// and the redirect/EPC outputs toward the fetch and eret muxes.
interface cp0_exc_if;
  logic [4:0]  cp0_addr;
  logic        mtc0_we;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic [31:0] pc_m;
  logic        bd_m;
  logic        exc_valid_m;
  logic [4:0]  exc_code_m;
  logic        eret_m;
  logic [5:0]  hw_int;
  logic        exc_take;
  logic [31:0] exc_pc;
  logic [31:0] epc_out;
  logic        exl_out;

  modport master (
    output cp0_addr, mtc0_we, wdata,
    output pc_m, bd_m, exc_valid_m,
    output exc_code_m, eret_m, hw_int,
    input  rdata, exc_take, exc_pc,
    input  epc_out, exl_out
  );

  modport slave (
    input  cp0_addr, mtc0_we, wdata,
    input  pc_m, bd_m, exc_valid_m,
    input  exc_code_m, eret_m, hw_int,
    output rdata, exc_take, exc_pc,
    output epc_out, exl_out
  );
endinterface

// File: rtl/cp0_exc_unit.sv
// Coprocessor-0 exception unit beside the M stage: SR, Cause, EPC,
// exception/interrupt entry, mtc0/mfc0 and eret EXL clear.
module cp0_exc_unit #(
  parameter logic [31:0] PRID    = 32'h0000_4300,
  parameter logic [31:0] HANDLER = 32'h0000_4180
) (
  input logic      clk,
  input logic      rst_n,
  cp0_exc_if.slave bus
);

  logic [5:0]  sr_im;
  logic        sr_exl;
  logic        sr_ie;
  logic        cause_bd;
  logic [5:0]  cause_ip;
  logic [4:0]  cause_exc;
  logic [31:0] epc_q;

  logic        irq;
  logic        take;
  logic [31:0] epc_next;
  logic [31:0] sr_word;
  logic [31:0] cause_word;
  logic [31:0] rd_data;
  logic        sel_sr;
  logic        sel_cause;
  logic        sel_epc;
  logic        sel_prid;

  // irq looks at the live lines so an interrupt is taken without IP lag
  assign irq = (|(bus.hw_int & sr_im))
             & sr_ie & ~sr_exl;
  assign take = ~sr_exl & (irq | bus.exc_valid_m);

  assign epc_next = (bus.bd_m
    ? bus.pc_m - 32'd4
    : bus.pc_m) & 32'hFFFF_FFFC;

  assign sr_word = {16'd0, sr_im, 8'd0,
                    sr_exl, sr_ie};
  assign cause_word = {cause_bd, 15'd0, cause_ip,
                       3'd0, cause_exc, 2'b00};

  assign sel_sr    = bus.cp0_addr == 5'd12;
  assign sel_cause = bus.cp0_addr == 5'd13;
  assign sel_epc   = bus.cp0_addr == 5'd14;
  assign sel_prid  = bus.cp0_addr == 5'd15;

  always_comb begin
    rd_data = 32'd0;
    unique case (1'b1)
      sel_sr:    rd_data = sr_word;
      sel_cause: rd_data = cause_word;
      sel_epc:   rd_data = epc_q;
      sel_prid:  rd_data = PRID;
      default:   rd_data = 32'd0;
    endcase
  end

  assign bus.rdata    = rd_data;
  assign bus.exc_take = take;
  assign bus.exc_pc   = HANDLER;
  assign bus.epc_out  = epc_q;
  assign bus.exl_out  = sr_exl;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sr_im     <= 6'd0;
      sr_exl    <= 1'b0;
      sr_ie     <= 1'b0;
      cause_bd  <= 1'b0;
      cause_ip  <= 6'd0;
      cause_exc <= 5'd0;
      epc_q     <= 32'd0;
    end else begin
      cause_ip <= bus.hw_int;
      if (take) begin
        sr_exl    <= 1'b1;
        cause_bd  <= bus.bd_m;
        cause_exc <= irq ? 5'd0 : bus.exc_code_m;
        epc_q     <= epc_next;
      end else begin
        if (bus.mtc0_we && sel_sr) begin
          sr_im  <= bus.wdata[15:10];
          sr_exl <= bus.wdata[1];
          sr_ie  <= bus.wdata[0];
        end
        if (bus.mtc0_we && sel_epc)
          epc_q <= bus.wdata & 32'hFFFF_FFFC;
        // eret wins over a same-cycle mtc0 to SR for EXL only
        if (bus.eret_m)
          sr_exl <= 1'b0;
      end
    end
  end

endmodule

// File: doc/cp0_exc_unit.md
# cp0_exc_unit

Coprocessor-0 exception unit for the 5-stage MIPS pipeline, sitting beside the M stage. It is the writer side of the EPC path. On exception or interrupt entry it captures the word-aligned restart PC into EPC, along with Status/Cause state. It serves `mtc0`/`mfc0` and clears EXL on `eret`. It exports the stored EPC to the `eret` target mux, which merges it with forwarded register values.

## Interface
- `PRID`, 32'h0000_4300: read-only value returned for CP0 register 15.
- `HANDLER`, 32'h0000_4180: exception vector driven on `exc_pc`.

- `clk` input 1: rising-edge clock.
- `rst_n` input 1: synchronous, active-low reset, sampled on the `clk` rising edge.
- `cp0_addr` input 5: CP0 register number (`rd` field) for `mtc0`/`mfc0`.
- `mtc0_we` input 1: write `wdata` to `cp0_addr` at the clock edge.
- `wdata` input 32: `mtc0` data, already forwarded.
- `rdata` output 32: combinational `mfc0` read of `cp0_addr`.
- `pc_m` input 32: PC of the instruction in M.
- `bd_m` input 1: the M instruction is in a branch delay slot.
- `exc_valid_m` input 1: the M instruction raised an internal exception.
- `exc_code_m` input 5: ExcCode of that exception.
- `eret_m` input 1: an `eret` is in M.
- `hw_int` input 6: hardware interrupt lines, level-sensitive.
- `exc_take` output 1: combinational; flush the pipeline and redirect to `exc_pc`.
- `exc_pc` output 32: constant `HANDLER`.
- `epc_out` output 32: current EPC register, bits [1:0] always 0.
- `exl_out` output 1: Status.EXL.

## Operation
- **State registers**
  - SR (reg 12): IM[15:10], EXL[1], IE[0]. All other bits read 0.
  - Cause (reg 13): BD[31], IP[15:10], ExcCode[6:2]. All other bits read 0.
  - EPC (reg 14): bits [31:2] stored; bits [1:0] always 0.
  - PRId (reg 15): equals `PRID`.
  - Any other address reads 0; writes to it are ignored.
- **IP update:** Cause.IP loads `hw_int` every cycle and is not writable by software.
- **Interrupt request:** `irq = |(hw_int & SR.IM) & SR.IE & ~SR.EXL`. It is computed from the live `hw_int`, not from the registered IP.
- **Take condition:** `exc_take = ~SR.EXL & (irq | exc_valid_m)`.
- **On take, at the next edge:**
  - SR.EXL <= 1.
  - Cause.BD <= `bd_m`.
  - Cause.ExcCode <= 0 if `irq`, else `exc_code_m`. Interrupts have priority over internal exceptions.
  - EPC[31:2] <= (`bd_m` ? `pc_m`-4 : `pc_m`)[31:2].
- **`eret_m` without take:** SR.EXL <= 0 at the edge. `epc_out` is unaffected.
- **`mtc0_we` without take:**
  - SR takes IM, EXL and IE from `wdata`.
  - Cause is not writable; the write is ignored.
  - EPC <= {`wdata`[31:2], 2'b00}.
  - PRId is read-only.
- **Simultaneous events**
  - Take beats `mtc0` and `eret`: both are suppressed in that cycle.
  - `eret` together with `mtc0` to SR: the `mtc0` write applies first, then EXL is forced to 0.
- **EPC bypass:** none. A consumer needing an EPC written in the same cycle uses its own forwarding path.

## Timing
- **Reset** (`rst_n`=0 at an edge):
  - SR = 0, Cause = 0, EPC = 0.
  - Hence `epc_out` = 0, `exl_out` = 0 and `exc_take` = 0 (IE=0, `exc_valid_m`=0 assumed in reset).
  - Reset has priority over take, `mtc0` and `eret` in the same cycle.
- **Combinational paths:** `exc_take` and `rdata` are combinational; there is no added latency.
- **Register visibility:** EPC, SR and Cause updates are visible on `epc_out`, `exl_out` and `rdata` the cycle after the edge.
- **Read during write:** `mfc0` in the same cycle as `mtc0` to the same register returns the old value.
- **Nested entry:** while EXL=1, no new take occurs even if `exc_valid_m` is asserted. EPC holds its value.
- **EPC arithmetic:** `pc_m`-4 is mod 2^32, so `pc_m`=0 with BD=1 gives EPC = 32'hFFFF_FFFC.

## Test plan
- **Reset:** `rst_n`=0 mid-run after EPC=32'h1234 -> next cycle `epc_out`=0, `exl_out`=0, `rdata`@12=0.
- **Internal exception:** `exc_valid_m`=1, `exc_code_m`=12, `pc_m`=32'h0000_3010, `bd_m`=0 ->
  - Same cycle: `exc_take`=1.
  - Next cycle: `epc_out`=32'h3010, `rdata`@13=12<<2, `exl_out`=1.
- **Delay slot:** `bd_m`=1, `pc_m`=32'h3024 -> `epc_out`=32'h3020, Cause.BD=1.
- **Interrupt vs exception:** SR=32'h0000_0401 (IM[10], IE), `hw_int`=6'b000001, `exc_valid_m`=1 code 10 in the same cycle -> `exc_take`=1, ExcCode=0.
  - Repeat with IE=0 -> ExcCode=10.
- **EXL blocking and `eret`:** with EXL=1, assert `exc_valid_m` -> `exc_take`=0 and EPC unchanged.
  - Then `eret_m`=1 -> next cycle `exl_out`=0; `epc_out` unchanged.
- **`mtc0` and priority:**
  - `mtc0` EPC `wdata`=32'h0000_3007 -> `epc_out`=32'h3004.
  - `mtc0` to Cause -> no change.
  - `mtc0` EPC in the same cycle as a take -> EPC holds the take PC, not `wdata`.
